enc_frame_sequencer: RTL and testbench
======================================

Name: enc_frame_sequencer

Overview:
- Frame-level controller that drives the 8b/10b encoder input on every cycle.
- At link start it pulses the encoder's running-disparity restart (startin), then sends a training run of K28.5 commas.
- After training, it wraps each upstream byte frame as SOF K27.7, payload data bytes, then EOF K29.7; K28.5 idles are sent between frames.
- Frames longer than MAX_LEN are aborted and the remainder of the frame is drained.

Parameters:
- STARTUP_COMMAS, 8: number of K28.5 symbols sent after startin before the first IDLE (≥1).
- MIN_IDLE, 4: minimum number of K28.5 idles between EOF/abort and the next SOF (≥1).
- MAX_LEN, 256: maximum number of payload bytes per frame (2..65535).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_en  in  1  transmit enable; gates idle emission and new frame starts.
- frame_pushin  in  1  upstream byte valid.
- frame_data  in  8  upstream payload byte.
- frame_last  in  1  marks the final byte of a frame; qualified by frame_pushin.
- frame_stall  out  1  backpressure; a byte is accepted only when frame_pushin=1 and frame_stall=0.
- datain  out  8  byte to the encoder.
- kin  out  1  1 = datain is a K-code.
- pushin  out  1  datain/kin valid to the encoder this cycle.
- startin  out  1  one-cycle pulse that restarts the encoder running disparity to RD−.
- frame_count  out  16  count of frames completed with EOF; wraps at 0xFFFF→0.
- err_trunc  out  1  one-cycle pulse when a frame is aborted for exceeding MAX_LEN.
- busy  out  1  1 in SOF, DATA, EOF, ABORT and DRAIN.

Behaviour:
- All outputs are registered; frame_stall is also registered and reflects the current state.
- The symbol decided by the state in cycle n is presented on datain/kin/pushin in cycle n+1 (latency 1).
- Reset (synchronous, any state, including mid-frame): enter INIT. All outputs are 0 and frame_stall=1. The idle, length and startup counters clear. frame_count clears.
- States and transitions:
  - INIT: one cycle. startin=1, pushin=0. Next state: STARTUP.
  - STARTUP: emit K28.5 (0xBC, kin=1) for STARTUP_COMMAS cycles, then go to IDLE. tx_en is ignored in this state.
  - IDLE: if tx_en=1, emit K28.5 and increment idle_cnt (saturating at MIN_IDLE). If tx_en=0, pushin=0 and idle_cnt holds. When idle_cnt≥MIN_IDLE, tx_en=1 and frame_pushin=1, go to SOF; the byte is not consumed in this cycle.
  - SOF: emit K27.7 (0xFB, kin=1). len_cnt←0. Next state: DATA.
  - DATA: frame_stall=0.
    - Accepted byte: emit it with kin=0 and increment len_cnt.
    - If frame_last=1, go to EOF.
    - Else if the accepted byte is the MAX_LEN-th byte, go to ABORT.
    - No byte this cycle (underrun): emit filler K28.0 (0x1C, kin=1) and stay in DATA.
  - EOF: emit K29.7 (0xFD, kin=1). frame_count++. idle_cnt←0. Next state: IDLE.
  - ABORT: emit K30.7 (0xFE, kin=1). Pulse err_trunc. idle_cnt←0. frame_count is not incremented.
    - If the previous accepted byte had frame_last=1, go to IDLE (impossible by construction, since last takes priority).
    - Otherwise go to DRAIN.
  - DRAIN: frame_stall=0. Accepted bytes are discarded. Emit K28.5 each cycle. An accepted byte with frame_last=1 sends the block to IDLE.
- frame_last set on the MAX_LEN-th byte has priority: the frame ends with EOF, not ABORT.
- tx_en deasserted mid-frame has no effect; the frame completes. tx_en is sampled only in IDLE.
- frame_stall=1 in INIT, STARTUP, IDLE, SOF, EOF and ABORT.
- pushin=1 every cycle except INIT, the cycle after reset, and IDLE with tx_en=0.

Test Plan:
- Reset released, tx_en=1, no frames → cycle 1: startin=1, pushin=0; then 8×(0xBC, kin=1); then continuous 0xBC; frame_count=0.
- 3-byte frame 0x11, 0x22, 0x33 (last on 0x33) offered after startup → output 0xFB k1, 0x11 k0, 0x22 k0, 0x33 k0, 0xFD k1, then ≥4×0xBC. frame_count=1. frame_stall=0 only during the 3 accept cycles.
- Back-to-back frames offered continuously → exactly MIN_IDLE=4 K28.5 symbols between EOF and the next SOF.
- DATA underrun (frame_pushin low for 2 cycles mid-frame) → two 0x1C k1 fillers inserted; payload order is unchanged.
- MAX_LEN=4, 6-byte frame:
  - → 4 data bytes, then 0xFE k1 with err_trunc=1 for one cycle.
  - Bytes 5–6 are swallowed while 0xBC is emitted.
  - frame_count is unchanged.
  - Separately, a 4-byte frame with last on byte 4 → EOF, err_trunc=0.
- reset asserted mid-DATA → the next cycle shows all outputs 0, then the INIT/startin sequence repeats; frame_count=0.

Source files
------------

// File: rtl/enc_frame_sequencer_if.sv
// Purpose: upstream byte-frame bus between a frame source and the encoder frame sequencer.
// Latency: none; this is a plain bundle of wires.
// Backpressure: the source may present a byte on any cycle, and the byte is taken only when frame_pushin=1 and frame_stall=0.
interface enc_frame_sequencer_if;
  logic       frame_pushin;
  logic [7:0] frame_data;
  logic       frame_last;
  logic       frame_stall;

  modport master (output frame_pushin, frame_data, frame_last, input frame_stall);
  modport slave  (input frame_pushin, frame_data, frame_last, output frame_stall);
endinterface

// File: rtl/enc_frame_sequencer.sv
// Purpose: drives the 8b/10b encoder input with startup commas, then idles and SOF/data/EOF-framed payload, aborting over-long frames.
// Latency: the symbol chosen in cycle n appears on datain/kin/pushin in cycle n+1.
// Backpressure: frame_stall is registered and is low only in DATA and DRAIN. During DATA underruns, K28.0 fillers are sent.
module enc_frame_sequencer #(
  parameter int STARTUP_COMMAS = 8,
  parameter int MIN_IDLE       = 4,
  parameter int MAX_LEN        = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_en,
  enc_frame_sequencer_if.slave frm,
  output logic [7:0]           datain,
  output logic                 kin,
  output logic                 pushin,
  output logic                 startin,
  output logic [15:0]          frame_count,
  output logic                 err_trunc,
  output logic                 busy
);
  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_STARTUP = 3'd1;
  localparam logic [2:0] ST_IDLE    = 3'd2;
  localparam logic [2:0] ST_SOF     = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_EOF     = 3'd5;
  localparam logic [2:0] ST_ABORT   = 3'd6;
  localparam logic [2:0] ST_DRAIN   = 3'd7;

  localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle
  localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
  localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
  localparam logic [7:0] K30_7 = 8'hFE;  // frame aborted
  localparam logic [7:0] K28_0 = 8'h1C;  // underrun filler

  localparam int SU_W = (STARTUP_COMMAS > 1) ? $clog2(STARTUP_COMMAS) : 1;
  localparam int ID_W = $clog2(MIN_IDLE + 1);
  localparam logic [SU_W-1:0] SU_LAST  = SU_W'(STARTUP_COMMAS - 1);
  localparam logic [ID_W-1:0] ID_MAX   = ID_W'(MIN_IDLE);
  localparam logic [15:0]     LEN_LAST = 16'(MAX_LEN - 1);

  logic [2:0]      state, state_nxt;
  logic [SU_W-1:0] su_cnt, su_cnt_nxt;
  logic [ID_W-1:0] idle_cnt, idle_cnt_nxt, idle_inc;
  logic [15:0]     len_cnt, len_cnt_nxt;
  logic [15:0]     count_nxt;
  logic            stall_q;
  logic            accept;
  logic [7:0]      sym_dat;
  logic            sym_k, sym_vld, start_nxt, trunc_nxt;

  assign frm.frame_stall = stall_q;
  assign accept          = frm.frame_pushin & ~stall_q;
  // The idle count includes the comma sent this cycle. As a result, a SOF follows exactly MIN_IDLE idles.
  assign idle_inc        = (idle_cnt == ID_MAX) ? idle_cnt : idle_cnt + 1'b1;

  // Choose the next state and the symbol for the next cycle.
  always_comb begin
    state_nxt    = state;
    su_cnt_nxt   = su_cnt;
    idle_cnt_nxt = idle_cnt;
    len_cnt_nxt  = len_cnt;
    count_nxt    = frame_count;
    sym_dat      = 8'h00;
    sym_k        = 1'b0;
    sym_vld      = 1'b0;
    start_nxt    = 1'b0;
    trunc_nxt    = 1'b0;
    case (state)
      ST_INIT: begin
        start_nxt  = 1'b1;
        su_cnt_nxt = '0;
        state_nxt  = ST_STARTUP;
      end
      ST_STARTUP: begin
        sym_vld = 1'b1;
        sym_k   = 1'b1;
        sym_dat = K28_5;
        if (su_cnt == SU_LAST) state_nxt = ST_IDLE;
        else                   su_cnt_nxt = su_cnt + 1'b1;
      end
      ST_IDLE: begin
        if (tx_en) begin
          sym_vld      = 1'b1;
          sym_k        = 1'b1;
          sym_dat      = K28_5;
          idle_cnt_nxt = idle_inc;
          if (idle_inc == ID_MAX && frm.frame_pushin) state_nxt = ST_SOF;
        end
      end
      ST_SOF: begin
        sym_vld     = 1'b1;
        sym_k       = 1'b1;
        sym_dat     = K27_7;
        len_cnt_nxt = '0;
        state_nxt   = ST_DATA;
      end
      ST_DATA: begin
        sym_vld = 1'b1;
        if (accept) begin
          sym_dat     = frm.frame_data;
          len_cnt_nxt = len_cnt + 16'd1;
          // When the final byte is also the MAX_LEN-th byte, the frame ends cleanly.
          if (frm.frame_last)          state_nxt = ST_EOF;
          else if (len_cnt == LEN_LAST) state_nxt = ST_ABORT;
        end else begin
          sym_k   = 1'b1;
          sym_dat = K28_0;
        end
      end
      ST_EOF: begin
        sym_vld      = 1'b1;
        sym_k        = 1'b1;
        sym_dat      = K29_7;
        count_nxt    = frame_count + 16'd1;
        idle_cnt_nxt = '0;
        state_nxt    = ST_IDLE;
      end
      ST_ABORT: begin
        sym_vld      = 1'b1;
        sym_k        = 1'b1;
        sym_dat      = K30_7;
        trunc_nxt    = 1'b1;
        idle_cnt_nxt = '0;
        state_nxt    = ST_DRAIN;
      end
      ST_DRAIN: begin
        sym_vld = 1'b1;
        sym_k   = 1'b1;
        sym_dat = K28_5;
        if (accept && frm.frame_last) state_nxt = ST_IDLE;
      end
    endcase
  end

  // Register the state, the counters and all outputs. Stall and busy follow the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_INIT;
      su_cnt      <= '0;
      idle_cnt    <= '0;
      len_cnt     <= '0;
      frame_count <= '0;
      datain      <= 8'h00;
      kin         <= 1'b0;
      pushin      <= 1'b0;
      startin     <= 1'b0;
      err_trunc   <= 1'b0;
      busy        <= 1'b0;
      stall_q     <= 1'b1;
    end else begin
      state       <= state_nxt;
      su_cnt      <= su_cnt_nxt;
      idle_cnt    <= idle_cnt_nxt;
      len_cnt     <= len_cnt_nxt;
      frame_count <= count_nxt;
      datain      <= sym_dat;
      kin         <= sym_k;
      pushin      <= sym_vld;
      startin     <= start_nxt;
      err_trunc   <= trunc_nxt;
      busy        <= (state_nxt == ST_SOF) || (state_nxt == ST_DATA) || (state_nxt == ST_EOF) ||
                     (state_nxt == ST_ABORT) || (state_nxt == ST_DRAIN);
      stall_q     <= !((state_nxt == ST_DATA) || (state_nxt == ST_DRAIN));
    end
  end
endmodule

// File: tb/tb_enc_frame_sequencer.sv
// Purpose: self-checking bench for enc_frame_sequencer with a cycle table, directed corner cases and random frames.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: the bench source offers bytes at random and retires a byte only when pushin=1 and stall=0.
module tb_enc_frame_sequencer;
  localparam int STARTUP_COMMAS = 8;
  localparam int MIN_IDLE       = 4;
  localparam int MAX_LEN        = 4;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] K28_0 = 8'h1C;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        tx_en = 1'b0;
  logic [7:0]  datain;
  logic        kin, pushin, startin, err_trunc, busy;
  logic [15:0] frame_count;

  enc_frame_sequencer_if frm ();

  enc_frame_sequencer #(
    .STARTUP_COMMAS(STARTUP_COMMAS),
    .MIN_IDLE      (MIN_IDLE),
    .MAX_LEN       (MAX_LEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_en      (tx_en),
    .frm        (frm),
    .datain     (datain),
    .kin        (kin),
    .pushin     (pushin),
    .startin    (startin),
    .frame_count(frame_count),
    .err_trunc  (err_trunc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, tx, pv, last;
    logic [7:0]  dat;
    logic        e_pv, e_k, e_st, e_stall, e_busy;
    logic [7:0]  e_dat;
    logic [15:0] e_fc;
  } vec_t;
  typedef struct { logic [7:0] d; logic last; int hold; } src_t;
  typedef struct { logic [7:0] d; logic k; logic err; } tok_t;

  vec_t        vecs[$];
  src_t        src_q[$];
  tok_t        exp_q[$];
  int          gap_log[$];
  int          nvec = 0, nerr = 0;
  int          p_pct = 100, tx_pct = 100;
  bit          auto_src = 1'b0, parse_en = 1'b0, in_frame = 1'b0;
  int          gap = 0, fill = 0, last_fill = 0, err_obs = 0, exp_aborts = 0;
  logic [15:0] exp_frames = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic rst, input logic tx, input logic pv, input logic [7:0] d,
                         input logic l, input logic e_pv, input logic e_k, input logic [7:0] e_d,
                         input logic e_st, input logic e_stall, input logic e_busy,
                         input logic [15:0] e_fc);
    vec_t v;
    v.rst = rst; v.tx = tx; v.pv = pv; v.dat = d; v.last = l;
    v.e_pv = e_pv; v.e_k = e_k; v.e_dat = e_d; v.e_st = e_st;
    v.e_stall = e_stall; v.e_busy = e_busy; v.e_fc = e_fc;
    vecs.push_back(v);
  endtask

  // Queue a frame at the source, together with the token stream it should produce on the encoder side.
  task automatic send_frame(input int n, input int hold_at, input int hold_len);
    src_t s;
    tok_t t;
    t.d = K27_7; t.k = 1'b1; t.err = 1'b0;
    exp_q.push_back(t);
    for (int i = 0; i < n; i++) begin
      s.d    = 8'($urandom_range(255));
      s.last = (i == n - 1);
      s.hold = (i == hold_at) ? hold_len : 0;
      src_q.push_back(s);
      if (i < MAX_LEN) begin
        t.d = s.d; t.k = 1'b0; t.err = 1'b0;
        exp_q.push_back(t);
      end
    end
    if (n <= MAX_LEN) begin
      t.d = K29_7; t.k = 1'b1; t.err = 1'b0;
      exp_frames++;
    end else begin
      t.d = K30_7; t.k = 1'b1; t.err = 1'b1;
      exp_aborts++;
    end
    exp_q.push_back(t);
  endtask

  // Classify each emitted symbol. K28.5 and K28.0 are checked for placement, and every other symbol must match the expected tokens in order.
  task automatic observe();
    tok_t e;
    if (err_trunc) err_obs++;
    if (pushin) begin
      if (kin && datain == K28_5) begin
        chk("idle_outside_frame", 64'(in_frame), 64'd0);
        gap++;
      end else if (kin && datain == K28_0) begin
        chk("filler_inside_frame", 64'(in_frame), 64'd1);
        fill++;
      end else if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_symbol: actual k=%0b dat=%02h required none", kin, datain);
      end else begin
        e = exp_q.pop_front();
        chk("symbol", {54'd0, err_trunc, kin, datain}, {54'd0, e.err, e.k, e.d});
        if (e.k && e.d == K27_7) begin
          chk("idle_gap_min", 64'(gap >= MIN_IDLE), 64'd1);
          gap_log.push_back(gap);
          in_frame = 1'b1;
          fill     = 0;
        end else if (e.k) begin
          in_frame  = 1'b0;
          gap       = 0;
          last_fill = fill;
        end
      end
    end
  endtask

  task automatic drive();
    tx_en = ($urandom_range(99) < 32'(tx_pct));
    frm.frame_pushin = 1'b0;
    if (src_q.size() > 0) begin
      if (src_q[0].hold > 0) begin
        src_q[0].hold = src_q[0].hold - 1;
      end else if ($urandom_range(99) < 32'(p_pct)) begin
        frm.frame_pushin = 1'b1;
        frm.frame_data   = src_q[0].d;
        frm.frame_last   = src_q[0].last;
      end
    end
  endtask

  task automatic step();
    logic acc;
    acc = frm.frame_pushin & ~frm.frame_stall;
    @(posedge clk);
    #1;
    if (acc && auto_src && src_q.size() > 0) src_q.delete(0);
    if (parse_en) observe();
    if (auto_src) drive();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || src_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() > 0 || src_q.size() > 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s_timeout: actual %0d tokens pending required 0", name, exp_q.size());
    end
    repeat (MIN_IDLE + 2) step();
    chk({name, "_frame_count"}, 64'(frame_count), 64'(exp_frames));
    chk({name, "_err_pulses"}, 64'(err_obs), 64'(exp_aborts));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    frm.frame_pushin = 1'b0;
    frm.frame_data   = 8'h00;
    frm.frame_last   = 1'b0;

    // Cycle table covering reset, startup commas, the first idles and a 3-byte frame.
    add_vec(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 16'd0);
    add_vec(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0, 16'd0);
    for (int i = 0; i < STARTUP_COMMAS; i++) add_vec(0, 1, 0, 8'h00, 0, 1, 1, K28_5, 0, 1, 0, 16'd0);
    for (int i = 0; i < MIN_IDLE - 1; i++)   add_vec(0, 1, 1, 8'h11, 0, 1, 1, K28_5, 0, 1, 0, 16'd0);
    add_vec(0, 1, 1, 8'h11, 0, 1, 1, K28_5, 0, 1, 1, 16'd0);
    add_vec(0, 1, 1, 8'h11, 0, 1, 1, K27_7, 0, 0, 1, 16'd0);
    add_vec(0, 1, 1, 8'h11, 0, 1, 0, 8'h11, 0, 0, 1, 16'd0);
    add_vec(0, 1, 1, 8'h22, 0, 1, 0, 8'h22, 0, 0, 1, 16'd0);
    add_vec(0, 1, 1, 8'h33, 1, 1, 0, 8'h33, 0, 1, 1, 16'd0);
    add_vec(0, 1, 0, 8'h00, 0, 1, 1, K29_7, 0, 1, 0, 16'd1);
    for (int i = 0; i < MIN_IDLE; i++)       add_vec(0, 1, 0, 8'h00, 0, 1, 1, K28_5, 0, 1, 0, 16'd1);

    foreach (vecs[i]) begin
      reset            = vecs[i].rst;
      tx_en            = vecs[i].tx;
      frm.frame_pushin = vecs[i].pv;
      frm.frame_data   = vecs[i].dat;
      frm.frame_last   = vecs[i].last;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          {34'd0, pushin, kin, datain, startin, frm.frame_stall, busy, frame_count, err_trunc},
          {34'd0, vecs[i].e_pv, vecs[i].e_k, vecs[i].e_dat, vecs[i].e_st, vecs[i].e_stall,
           vecs[i].e_busy, vecs[i].e_fc, 1'b0});
    end

    // Hand the link over to the queued source. The table ended with MIN_IDLE idles after its EOF.
    exp_frames = 16'd1;
    gap        = MIN_IDLE;
    in_frame   = 1'b0;
    auto_src   = 1'b1;
    parse_en   = 1'b1;
    drive();

    // Back-to-back frames: every gap after the first must be exactly MIN_IDLE.
    p_pct = 100; tx_pct = 100;
    gap_log.delete();
    send_frame(2, -1, 0);
    send_frame(3, -1, 0);
    send_frame(1, -1, 0);
    send_frame(4, -1, 0);
    wait_done("b2b", 500);
    chk("b2b_frames_seen", 64'(gap_log.size()), 64'd4);
    for (int i = 1; i < gap_log.size(); i++) chk($sformatf("b2b_gap%0d", i), 64'(gap_log[i]), 64'(MIN_IDLE));

    // Underrun of two cycles before byte 3, in a frame whose last byte is the MAX_LEN-th.
    send_frame(MAX_LEN, 2, 2);
    wait_done("underrun", 500);
    chk("underrun_fillers", 64'(last_fill), 64'd2);

    // Over-long frame: truncated after MAX_LEN bytes, then the tail is drained.
    send_frame(MAX_LEN + 2, -1, 0);
    wait_done("abort", 500);

    // Random frame lengths around MAX_LEN, with random source gaps and random tx_en.
    p_pct = 70; tx_pct = 80;
    for (int i = 0; i < 30; i++) send_frame($urandom_range(1, MAX_LEN + 3), -1, 0);
    wait_done("random", 6000);

    // Reset while a frame is in DATA.
    p_pct = 100; tx_pct = 100;
    send_frame(MAX_LEN, -1, 0);
    n = 0;
    while (!(in_frame && exp_q.size() <= MAX_LEN) && n < 200) begin
      step();
      n++;
    end
    chk("reach_data_before_reset", 64'(in_frame && exp_q.size() <= MAX_LEN), 64'd1);
    auto_src = 1'b0;
    parse_en = 1'b0;
    src_q.delete();
    exp_q.delete();
    frm.frame_pushin = 1'b0;
    tx_en = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_outputs",
        {34'd0, pushin, kin, datain, startin, frm.frame_stall, busy, frame_count, err_trunc},
        {34'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0});
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_startin", {62'd0, startin, pushin}, {62'd0, 1'b1, 1'b0});
    for (int i = 0; i < STARTUP_COMMAS; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("restart_comma%0d", i), {55'd0, pushin, kin, datain}, {55'd0, 1'b1, 1'b1, K28_5});
    end
    chk("restart_frame_count", 64'(frame_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
